// File: rtl/mul_ctrl_path.sv
// Control FSM for the 15-bit repeated-addition multiplier: sequences A load, B load/P clear, then add/decrement until B == 0.
// Optional iteration limit with error flag is enabled by defining MUL_TIMEOUT_EN.
module mul_ctrl_path #(
  parameter int ITER_W   = 15,
  parameter int MAX_ITER = 32767
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              eqz,
  output logic              ld_a,
  output logic              ld_b,
  output logic              clr_p,
  output logic              ld_p,
  output logic              dec_b,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_ADD,
    S_DONE
  } state_t;

  state_t state;
  logic   iter_max;
  logic   limit_hit;

  assign iter_max = &iter_cnt;

`ifdef MUL_TIMEOUT_EN
  localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
  assign limit_hit = (iter_cnt == ITER_LIMIT);
`else
  logic unused_max_iter;
  assign limit_hit       = 1'b0;
  assign unused_max_iter = ^MAX_ITER;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            iter_cnt <= '0;
            err      <= 1'b0;
          end
        end
        S_LOAD_A: state <= S_LOAD_B;
        S_LOAD_B: state <= S_ADD;
        S_ADD: begin
          if (eqz) begin
            state <= S_DONE;
          end else if (limit_hit) begin
            state <= S_DONE;
            err   <= 1'b1;
          end else if (!iter_max) begin
            iter_cnt <= iter_cnt + ITER_W'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode straight from state so the datapath acts in the same cycle.
  assign ld_a  = (state == S_LOAD_A);
  assign ld_b  = (state == S_LOAD_B);
  assign clr_p = (state == S_LOAD_B);
  assign ld_p  = (state == S_ADD) && !eqz && !limit_hit;
  assign dec_b = ld_p;
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_mul_ctrl_path.sv
// Directed bench for mul_ctrl_path with a small A/B/P datapath model around it.
module tb_mul_ctrl_path;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        eqz;
  logic        ld_a, ld_b, clr_p, ld_p, dec_b, busy, done, err;
  logic [14:0] iter_cnt;

  logic [14:0] op_a, op_b, bus;
  logic [14:0] reg_a, reg_b, reg_p;

  int n_checks = 0;
  int n_pass   = 0;
  int overlap  = 0;
  int cyc_o;

  always #5 clk = ~clk;

`ifdef MUL_TIMEOUT_EN
  mul_ctrl_path #(.ITER_W(15), .MAX_ITER(4)) dut (
`else
  mul_ctrl_path #(.ITER_W(15), .MAX_ITER(32767)) dut (
`endif
    .clk(clk), .rst(rst), .start(start), .eqz(eqz),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .ld_p(ld_p), .dec_b(dec_b),
    .busy(busy), .done(done), .iter_cnt(iter_cnt), .err(err)
  );

  // Datapath model: bus carries A while ld_a is high, otherwise B.
  assign bus = ld_a ? op_a : op_b;
  assign eqz = (reg_b == 15'd0);

  always @(posedge clk) begin
    if (ld_a)  reg_a <= bus;
    if (ld_b)  reg_b <= bus;
    if (clr_p) reg_p <= 15'd0;
    if (ld_p)  reg_p <= reg_a + reg_p;
    if (dec_b) reg_b <= reg_b - 15'd1;
  end

  always @(negedge clk) begin
    if ((32'(ld_a) + 32'(ld_b) + 32'(ld_p)) > 1) overlap++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Start one multiply and follow it to done; cycle 1 is the LOAD_A cycle.
  task automatic run_mul(input logic [14:0] a, input logic [14:0] b,
                         input logic [14:0] exp_p, input int exp_iter,
                         input int exp_cyc, input logic exp_err,
                         input bit pulse_in_add, output int cyc);
    int n_ldp;
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    n_ldp = 0;
    check_eq("ld_a_cycle1", {31'd0, ld_a}, 32'd1);
    check_eq("busy_cycle1", {31'd0, busy}, 32'd1);
    while (!done && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      start = (pulse_in_add && cyc == 4);
      if (ld_p) n_ldp++;
      if (cyc == 2) check_eq("ldb_clrp_cycle2", {30'd0, ld_b, clr_p}, 32'd3);
    end
    start = 1'b0;
    check_eq("done_cycle", cyc, exp_cyc);
    check_eq("busy_at_done", {31'd0, busy}, 32'd1);
    check_eq("ld_p_count", n_ldp, exp_iter);
    check_eq("product", {17'd0, reg_p}, {17'd0, exp_p});
    check_eq("iter_cnt", {17'd0, iter_cnt}, exp_iter);
    check_eq("err_at_done", {31'd0, err}, {31'd0, exp_err});
    @(negedge clk);
    check_eq("idle_after_done", {30'd0, busy, done}, 32'd0);
    check_eq("iter_cnt_hold", {17'd0, iter_cnt}, exp_iter);
    check_eq("err_hold", {31'd0, err}, {31'd0, exp_err});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = 15'd0;
    op_b  = 15'd0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", {25'd0, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done}, 32'd0);
    check_eq("reset_iter", {17'd0, iter_cnt}, 32'd0);
    check_eq("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;

    // 5*3 with a stray start pulse during ADD
    run_mul(15'd5, 15'd3, 15'd15, 3, 7, 1'b0, 1'b1, cyc_o);
    run_mul(15'd9, 15'd0, 15'd0, 0, 4, 1'b0, 1'b0, cyc_o);
    run_mul(15'd32767, 15'd2, 15'd32766, 2, 6, 1'b0, 1'b0, cyc_o);

    // Reset during the second ADD cycle of 7*6
    @(negedge clk);
    op_a  = 15'd7;
    op_b  = 15'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_reset_add", {30'd0, ld_p, dec_b}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midadd_reset_out", {25'd0, ld_a, ld_b, clr_p, ld_p, dec_b, busy, done}, 32'd0);
    check_eq("midadd_reset_iter", {17'd0, iter_cnt}, 32'd0);
    run_mul(15'd2, 15'd2, 15'd4, 2, 6, 1'b0, 1'b0, cyc_o);

    // start held high: done, one IDLE cycle, then LOAD_A again
    @(negedge clk);
    op_a  = 15'd3;
    op_b  = 15'd2;
    start = 1'b1;
    cyc_o = 0;
    while (!done && cyc_o < 100) begin
      @(negedge clk);
      cyc_o++;
    end
    check_eq("held_done_cycle", cyc_o, 6);
    check_eq("held_product", {17'd0, reg_p}, 32'd6);
    @(negedge clk);
    check_eq("held_idle_gap", {30'd0, busy, ld_a}, 32'd0);
    @(negedge clk);
    check_eq("held_reload_a", {30'd0, busy, ld_a}, 32'd3);
    start = 1'b0;
    cyc_o = 0;
    while (!done && cyc_o < 100) begin
      @(negedge clk);
      cyc_o++;
    end
    check_eq("held_second_done", {31'd0, done}, 32'd1);
    @(negedge clk);

`ifdef MUL_TIMEOUT_EN
    run_mul(15'd3, 15'd10, 15'd12, 4, 8, 1'b1, 1'b0, cyc_o);
    run_mul(15'd3, 15'd2, 15'd6, 2, 6, 1'b0, 1'b0, cyc_o);
`else
    check_eq("err_tied_low", {31'd0, err}, 32'd0);
`endif

    check_eq("strobe_overlap", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
